spram_data_mem: RTL and testbench

//  Parametrised data memory for the processor, built from iCE40 SB_SPRAM256KA

---
 rtl/spram_data_mem_pkg.sv | 25 ++
 rtl/SB_SPRAM256KA.sv | 42 ++++
 rtl/spram_data_mem_bank.sv | 39 +++
 rtl/spram_data_mem.sv | 167 ++++++++++++++++
 tb/tb_spram_data_mem.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/spram_data_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spram_data_mem_pkg
//  Purpose  : Shared SPRAM geometry, power-state encodings and byte-enable to
//             nibble-mask helper for the SPRAM data memory.
//  Revision : 1.0  initial release
// ============================================================================
package spram_data_mem_pkg;

    localparam int unsigned SPRAM_DEPTH_LOG2 = 14;
    localparam int unsigned SPRAM_WIDTH      = 16;

    typedef enum logic [1:0] {
        PWR_ACTIVE = 2'b00,
        PWR_SLEEP  = 2'b01,
        PWR_WAKE   = 2'b10
    } pwr_state_t;

    // SPRAM write masks are per nibble; each byte enable covers two nibbles.
    function automatic logic [3:0] be_to_mask(input logic [1:0] i_be);
        return {{2{i_be[1]}}, {2{i_be[0]}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/SB_SPRAM256KA.sv
`default_nettype none
// ============================================================================
//  Module   : SB_SPRAM256KA
//  Purpose  : Behavioural model of the iCE40 16K x 16 single-port SPRAM; the
//             vendor cell replaces this file in an iCE40 implementation flow.
//  Revision : 1.0  initial release
// ============================================================================
module SB_SPRAM256KA (
    input  logic [13:0] ADDRESS,
    input  logic [15:0] DATAIN,
    input  logic [3:0]  MASKWREN,
    input  logic        WREN,
    input  logic        CHIPSELECT,
    input  logic        CLOCK,
    input  logic        STANDBY,
    input  logic        SLEEP,
    input  logic        POWEROFF,
    output logic [15:0] DATAOUT
);

    logic [15:0] r_mem [0:16383];
    logic        w_access;

    // Contents are retained through sleep; only accesses are blocked.
    assign w_access = CHIPSELECT & ~STANDBY & ~SLEEP & POWEROFF;

    always_ff @(posedge CLOCK) begin
        if (w_access) begin
            if (WREN) begin
                for (int n = 0; n < 4; n++) begin
                    if (MASKWREN[n]) begin
                        r_mem[ADDRESS][n*4 +: 4] <= DATAIN[n*4 +: 4];
                    end
                end
            end else begin
                DATAOUT <= r_mem[ADDRESS];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/spram_data_mem_bank.sv
`default_nettype none
// ============================================================================
//  Module   : spram_bank
//  Purpose  : One 16K-word bank: LANES SPRAMs side by side sharing address,
//             chip-select, write-enable and sleep, each owning a 16-bit slice.
//  Revision : 1.0  initial release
// ============================================================================
module spram_bank
    import spram_data_mem_pkg::*;
#(
    parameter int unsigned LANES = 2
) (
    input  logic                          clk,
    input  logic [SPRAM_DEPTH_LOG2-1:0]   i_addr,
    input  logic                          i_cs,
    input  logic                          i_we,
    input  logic                          i_sleep,
    input  logic [LANES*SPRAM_WIDTH-1:0]  i_wdata,
    input  logic [LANES*4-1:0]            i_mask,
    output logic [LANES*SPRAM_WIDTH-1:0]  o_rdata
);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        SB_SPRAM256KA u_spram (
            .ADDRESS    (i_addr),
            .DATAIN     (i_wdata[l*SPRAM_WIDTH +: SPRAM_WIDTH]),
            .MASKWREN   (i_mask[l*4 +: 4]),
            .WREN       (i_we),
            .CHIPSELECT (i_cs),
            .CLOCK      (clk),
            .STANDBY    (1'b0),
            .SLEEP      (i_sleep),
            .POWEROFF   (1'b1),
            .DATAOUT    (o_rdata[l*SPRAM_WIDTH +: SPRAM_WIDTH])
        );
    end

endmodule
`default_nettype wire

// File: rtl/spram_data_mem.sv
`default_nettype none
// ============================================================================
//  Module   : spram_data_mem
//  Purpose  : SPRAM-backed data memory with valid/ready requests, byte-enable
//             writes, 1-cycle read response and optional idle sleep manager
//             (enabled by defining SPRAM_DATA_MEM_SLEEP_EN).
//  Revision : 1.0  initial release
// ============================================================================
module spram_data_mem
    import spram_data_mem_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH  = 32,
    parameter  int unsigned BANKS       = 2,
    parameter  int unsigned IDLE_CYCLES = 64,
    parameter  int unsigned WAKE_CYCLES = 3,
    localparam int unsigned ADDR_W      = SPRAM_DEPTH_LOG2 + $clog2(BANKS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_be,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              pwr_state
);

    localparam int unsigned LANES  = DATA_WIDTH / SPRAM_WIDTH;
    localparam int unsigned BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;

    if ((DATA_WIDTH % SPRAM_WIDTH) != 0 || BANKS == 0 || (BANKS & (BANKS - 1)) != 0 ||
        LANES * BANKS > 4 || IDLE_CYCLES > 65535 || WAKE_CYCLES > 255) begin : g_bad_cfg
        $error("spram_data_mem: unsupported configuration");
    end

    logic                  w_accept;
    logic                  w_sleep;
    logic [BANK_W-1:0]     w_bank_sel;
    logic [LANES*4-1:0]    w_mask;
    logic [DATA_WIDTH-1:0] w_bank_rdata [BANKS];
    logic                  r_rsp_valid;
    logic [BANK_W-1:0]     r_rd_bank;
    logic [DATA_WIDTH-1:0] r_rdata_hold;

    assign w_accept = req_valid & req_ready;

    if (BANKS > 1) begin : g_bank_dec
        assign w_bank_sel = req_addr[ADDR_W-1 -: BANK_W];
    end else begin : g_single_bank
        assign w_bank_sel = '0;
    end

    for (genvar l = 0; l < LANES; l++) begin : g_mask
        assign w_mask[l*4 +: 4] = be_to_mask(req_be[l*2 +: 2]);
    end

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        spram_bank #(
            .LANES (LANES)
        ) u_bank (
            .clk     (clk),
            .i_addr  (req_addr[SPRAM_DEPTH_LOG2-1:0]),
            .i_cs    (w_accept && (w_bank_sel == BANK_W'(b))),
            .i_we    (req_we),
            .i_sleep (w_sleep),
            .i_wdata (req_wdata),
            .i_mask  (w_mask),
            .o_rdata (w_bank_rdata[b])
        );
    end

    // SPRAM output is already registered, so the bank select is registered
    // alongside it; the hold register keeps rsp_rdata stable between reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_valid  <= 1'b0;
            r_rd_bank    <= '0;
            r_rdata_hold <= '0;
        end else begin
            r_rsp_valid <= w_accept & ~req_we;
            if (w_accept && !req_we) begin
                r_rd_bank <= w_bank_sel;
            end
            if (r_rsp_valid) begin
                r_rdata_hold <= w_bank_rdata[r_rd_bank];
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_valid ? w_bank_rdata[r_rd_bank] : r_rdata_hold;

`ifdef SPRAM_DATA_MEM_SLEEP_EN
    localparam int unsigned IDLE_W = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
    localparam int unsigned WAKE_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;

    pwr_state_t        r_pwr;
    logic              r_req_ready;
    logic              r_sleep;
    logic [IDLE_W-1:0] r_idle_cnt;
    logic [WAKE_W-1:0] r_wake_cnt;
    logic              w_idle_hit;
    logic              w_wake_done;

    assign w_idle_hit  = (IDLE_CYCLES != 0) && (r_idle_cnt == IDLE_W'(IDLE_CYCLES - 1));
    assign w_wake_done = (WAKE_CYCLES <= 1) || (r_wake_cnt == WAKE_W'(WAKE_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pwr       <= PWR_ACTIVE;
            r_req_ready <= 1'b1;
            r_sleep     <= 1'b0;
            r_idle_cnt  <= '0;
            r_wake_cnt  <= '0;
        end else begin
            case (r_pwr)
                PWR_ACTIVE: begin
                    if (req_valid) begin
                        r_idle_cnt <= '0;
                    end else if (w_idle_hit) begin
                        r_pwr       <= PWR_SLEEP;
                        r_req_ready <= 1'b0;
                        r_sleep     <= 1'b1;
                        r_idle_cnt  <= '0;
                    end else if (r_idle_cnt != '1) begin
                        r_idle_cnt <= r_idle_cnt + 1'b1;
                    end
                end
                PWR_SLEEP: begin
                    if (req_valid) begin
                        r_pwr      <= PWR_WAKE;
                        r_sleep    <= 1'b0;
                        r_wake_cnt <= '0;
                    end
                end
                PWR_WAKE: begin
                    if (w_wake_done) begin
                        r_pwr       <= PWR_ACTIVE;
                        r_req_ready <= 1'b1;
                        r_wake_cnt  <= '0;
                    end else begin
                        r_wake_cnt <= r_wake_cnt + 1'b1;
                    end
                end
                default: begin
                    r_pwr       <= PWR_ACTIVE;
                    r_req_ready <= 1'b1;
                    r_sleep     <= 1'b0;
                end
            endcase
        end
    end

    assign w_sleep   = r_sleep;
    assign req_ready = r_req_ready;
    assign pwr_state = r_pwr;
`else
    assign w_sleep   = 1'b0;
    assign req_ready = 1'b1;
    assign pwr_state = PWR_ACTIVE;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spram_data_mem.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spram_data_mem
//  Purpose  : Directed self-checking bench for spram_data_mem (default
//             parameters; power tests follow SPRAM_DATA_MEM_SLEEP_EN).
//  Revision : 1.0  initial release
// ============================================================================
module tb_spram_data_mem;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [14:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  pwr_state;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    spram_data_mem #(
        .DATA_WIDTH  (32),
        .BANKS       (2),
        .IDLE_CYCLES (64),
        .WAKE_CYCLES (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .pwr_state (pwr_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [14:0] a, input logic [31:0] d, input logic [3:0] be);
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d; req_be = be;
        tick();
        req_valid = 1'b0; req_we = 1'b0;
    endtask

    task automatic start_read(input logic [14:0] a);
        req_valid = 1'b1; req_we = 1'b0; req_addr = a;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_addr = '0; req_wdata = '0; req_be = '0;
        tick(); tick();
        reset = 1'b0;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        n_cmp++; if (rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        n_cmp++; if (pwr_state !== 2'b00) begin n_bad++; $display("FAIL reset_pwr_state: got %b want 00", pwr_state); end
    endtask

    task automatic test_write_read();
        do_write(15'h0010, 32'hDEADBEEF, 4'b1111);
        start_read(15'h0010);
        tick();
        req_valid = 1'b0;
        n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL wr_rd_valid: got %b want 1", rsp_valid); end
        n_cmp++; if (rsp_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wr_rd_data: got %h want deadbeef", rsp_rdata); end
        tick();
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rsp_valid_drop: got %b want 0", rsp_valid); end
        n_cmp++; if (rsp_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rdata_hold: got %h want deadbeef", rsp_rdata); end
    endtask

    task automatic test_byte_enable();
        do_write(15'h0020, 32'h11223344, 4'b1111);
        do_write(15'h0020, 32'hAABBCCDD, 4'b0101);
        start_read(15'h0020);
        tick();
        req_valid = 1'b0;
        n_cmp++; if (rsp_rdata !== 32'h11BB33DD) begin n_bad++; $display("FAIL be_0101: got %h want 11bb33dd", rsp_rdata); end
        do_write(15'h0020, 32'hFFFFFFFF, 4'b0000);
        start_read(15'h0020);
        tick();
        req_valid = 1'b0;
        n_cmp++; if (rsp_rdata !== 32'h11BB33DD) begin n_bad++; $display("FAIL be_zero: got %h want 11bb33dd", rsp_rdata); end
        do_write(15'h0020, 32'h00EE0000, 4'b0100);
        start_read(15'h0020);
        tick();
        req_valid = 1'b0;
        n_cmp++; if (rsp_rdata !== 32'h11EE33DD) begin n_bad++; $display("FAIL be_0100: got %h want 11ee33dd", rsp_rdata); end
    endtask

    task automatic test_back_to_back();
        req_valid = 1'b1; req_we = 1'b1; req_be = 4'b1111;
        req_addr = 15'h0005; req_wdata = 32'hA5A5A5A5;
        tick();
        req_addr = 15'h4005; req_wdata = 32'h5A5A5A5A;
        tick();
        start_read(15'h0005);
        tick();
        req_addr = 15'h4005;
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hA5A5A5A5) begin
            n_bad++; $display("FAIL b2b_bank0: got v=%b %h want v=1 a5a5a5a5", rsp_valid, rsp_rdata); end
        tick();
        req_valid = 1'b0;
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h5A5A5A5A) begin
            n_bad++; $display("FAIL b2b_bank1: got v=%b %h want v=1 5a5a5a5a", rsp_valid, rsp_rdata); end
        tick();
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_end_valid: got %b want 0", rsp_valid); end
    endtask

    task automatic test_raw();
        req_valid = 1'b1; req_we = 1'b1; req_be = 4'b1111;
        req_addr = 15'h4030; req_wdata = 32'hCAFEF00D;
        tick();
        req_we = 1'b0;
        tick();
        req_valid = 1'b0;
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFEF00D) begin
            n_bad++; $display("FAIL raw_next_cycle: got v=%b %h want v=1 cafef00d", rsp_valid, rsp_rdata); end
        start_read(15'h0030);
        tick();
        req_valid = 1'b0;
        n_cmp++; if (rsp_rdata === 32'hCAFEF00D) begin
            n_bad++; $display("FAIL raw_alias: got %h at bank0 want not cafef00d", rsp_rdata); end
    endtask

`ifdef SPRAM_DATA_MEM_SLEEP_EN
    task automatic test_sleep_wake();
        start_read(15'h0010);
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 63; i++) tick();
        n_cmp++; if (pwr_state !== 2'b00) begin n_bad++; $display("FAIL idle63_active: got %b want 00", pwr_state); end
        tick();
        n_cmp++; if (pwr_state !== 2'b01 || req_ready !== 1'b0) begin
            n_bad++; $display("FAIL enter_sleep: got st=%b rdy=%b want st=01 rdy=0", pwr_state, req_ready); end
        start_read(15'h0010);
        for (int w = 0; w < 3; w++) begin
            tick();
            n_cmp++; if (pwr_state !== 2'b10 || req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
                n_bad++; $display("FAIL wake_cycle%0d: got st=%b rdy=%b v=%b want st=10 rdy=0 v=0",
                                  w, pwr_state, req_ready, rsp_valid); end
        end
        tick();
        n_cmp++; if (pwr_state !== 2'b00 || req_ready !== 1'b1) begin
            n_bad++; $display("FAIL wake_done: got st=%b rdy=%b want st=00 rdy=1", pwr_state, req_ready); end
        tick();
        req_valid = 1'b0;
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF) begin
            n_bad++; $display("FAIL wake_read: got v=%b %h want v=1 deadbeef", rsp_valid, rsp_rdata); end
    endtask

    task automatic test_threshold();
        start_read(15'h0010);
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 63; i++) tick();
        start_read(15'h0005);
        tick();
        req_valid = 1'b0;
        n_cmp++; if (pwr_state !== 2'b00 || rsp_valid !== 1'b1 || rsp_rdata !== 32'hA5A5A5A5) begin
            n_bad++; $display("FAIL threshold_wins: got st=%b v=%b %h want st=00 v=1 a5a5a5a5",
                              pwr_state, rsp_valid, rsp_rdata); end
        for (int i = 0; i < 63; i++) tick();
        n_cmp++; if (pwr_state !== 2'b00) begin n_bad++; $display("FAIL cnt_cleared: got %b want 00", pwr_state); end
        tick();
        n_cmp++; if (pwr_state !== 2'b01) begin n_bad++; $display("FAIL resleep: got %b want 01", pwr_state); end
        start_read(15'h0010);
        tick();
        n_cmp++; if (pwr_state !== 2'b10) begin n_bad++; $display("FAIL rewake: got %b want 10", pwr_state); end
        req_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++; if (pwr_state !== 2'b00 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_in_wake: got st=%b v=%b rdy=%b want st=00 v=0 rdy=1",
                              pwr_state, rsp_valid, req_ready); end
    endtask
`else
    task automatic test_no_sleep();
        int bad_cycles;
        bad_cycles = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (pwr_state !== 2'b00 || req_ready !== 1'b1) bad_cycles++;
        end
        n_cmp++; if (bad_cycles != 0) begin
            n_bad++; $display("FAIL no_sleep_idle: got %0d bad cycles (st=%b rdy=%b) want 0",
                              bad_cycles, pwr_state, req_ready); end
        start_read(15'h0010);
        tick();
        req_valid = 1'b0;
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF) begin
            n_bad++; $display("FAIL no_sleep_read: got v=%b %h want v=1 deadbeef", rsp_valid, rsp_rdata); end
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_byte_enable();
        test_back_to_back();
        test_raw();
`ifdef SPRAM_DATA_MEM_SLEEP_EN
        test_sleep_wake();
        test_threshold();
`else
        test_no_sleep();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
